csw_tape_player: RTL and testbench

- Streams a CSW v1 pulse body, downloaded through the ioctl path, into a replayed cassette level that drives the motherboard `tape_in` input.
- Sits upstream of the tape input of the Amstrad motherboard, alongside the `UART_RX` tape source.
- Buffers incoming bytes in an internal FIFO and decodes the pulse lengths.
- Toggles the output level at `ce_sample` granularity and pauses whenever the CPC tape motor is off.

---
 rtl/csw_tape_player.sv | 191 +++++++++++++++++++
 tb/tb_csw_tape_player.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csw_tape_player.sv
// CSW v1 pulse-body player: buffers streamed bytes in a FIFO, decodes pulse
// lengths (short 1-byte or 0-prefixed 32-bit LE) and toggles the tape level.
module csw_tape_player #(
    parameter int FIFO_AW    = 10,
    parameter bit INIT_LEVEL = 1'b0
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ce_sample,
    input  logic               motor,
    input  logic               flush,
    input  logic [7:0]         din,
    input  logic               din_wr,
    output logic               din_ready,
    output logic               tape_level,
    output logic               active,
    output logic               underrun,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_GET, S_EXT_RD, S_EXT_GET, S_PLAY
    } state_t;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic [7:0]         r_rd_data;

    state_t             r_state;
    state_t             w_state_nx;
    logic [31:0]        r_cnt;
    logic [1:0]         r_idx;
    logic               r_level;
    logic               r_underrun;
    logic               r_active;
    logic               r_pulse_done;

    logic               w_full;
    logic               w_empty;
    logic               w_wr;
    logic               w_rd;
    logic               w_strobe;
    logic               w_toggle;
    logic               w_underrun_set;
    logic [31:0]        w_ext_val;

    assign w_full     = (r_count == (FIFO_AW+1)'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_wr       = din_wr && !w_full && !flush;

    assign din_ready  = !w_full;
    assign fifo_count = r_count;
    assign tape_level = r_level;
    assign underrun   = r_underrun;
    assign active     = r_active;

    // Byte 3 arrives straight from the FIFO; bytes 0..2 are already in r_cnt.
    assign w_ext_val  = {r_rd_data, r_cnt[23:0]};

    // ---------------- FIFO ----------------
    always_ff @(posedge clk_sys) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else if (flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else if (flush)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:    if (!w_empty) w_state_nx = S_RD;
            S_RD:      if (!w_empty) w_state_nx = S_GET;
            S_GET:     w_state_nx = (r_rd_data != 8'd0) ? S_PLAY : S_EXT_RD;
            S_EXT_RD:  if (!w_empty) w_state_nx = S_EXT_GET;
            S_EXT_GET: begin
                if (r_idx == 2'd3)
                    w_state_nx = (w_ext_val != 32'd0) ? S_PLAY : S_RD;
                else
                    w_state_nx = S_EXT_RD;
            end
            S_PLAY:    if (w_toggle) w_state_nx = S_RD;
            default:   w_state_nx = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / controls ----------------
    always_comb begin
        w_rd           = 1'b0;
        w_strobe       = 1'b0;
        w_toggle       = 1'b0;
        w_underrun_set = 1'b0;
        case (r_state)
            S_RD: begin
                w_rd           = !w_empty && !flush;
                // Waiting for the very first pulse is not an underrun.
                w_underrun_set = w_empty && r_pulse_done;
            end
            S_EXT_RD: begin
                w_rd           = !w_empty && !flush;
                w_underrun_set = w_empty;
            end
            S_PLAY: begin
                w_strobe = ce_sample && motor;
                w_toggle = ce_sample && motor && (r_cnt == 32'd1);
            end
            default: ;
        endcase
    end

    // ---------------- Pulse datapath ----------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_level      <= INIT_LEVEL;
            r_underrun   <= 1'b0;
            r_active     <= 1'b0;
            r_pulse_done <= 1'b0;
        end else if (flush) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_level      <= INIT_LEVEL;
            r_underrun   <= 1'b0;
            r_active     <= 1'b0;
            r_pulse_done <= 1'b0;
        end else begin
            case (r_state)
                S_GET: begin
                    r_cnt <= {24'd0, r_rd_data};
                    r_idx <= '0;
                end
                S_EXT_GET: begin
                    r_cnt[{r_idx, 3'b000} +: 8] <= r_rd_data;
                    r_idx <= r_idx + 2'd1;
                end
                S_PLAY: begin
                    if (w_strobe)
                        r_cnt <= r_cnt - 32'd1;
                    if (w_toggle) begin
                        r_level      <= !r_level;
                        r_pulse_done <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_underrun_set)
                r_underrun <= 1'b1;
            r_active <= (r_state == S_PLAY) && motor;
        end
    end

endmodule

// File: tb/tb_csw_tape_player.sv
// Scoreboard bench for csw_tape_player: expected toggles (level, qualified
// strobe index) are queued by stimulus and popped by a level-change monitor.
module tb_csw_tape_player;

    localparam int AW = 10;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          ce_sample = 1'b0;
    logic          motor = 1'b0;
    logic          flush = 1'b0;
    logic [7:0]    din = '0;
    logic          din_wr = 1'b0;
    logic          din_ready;
    logic          tape_level;
    logic          active;
    logic          underrun;
    logic [AW:0]   fifo_count;

    csw_tape_player #(.FIFO_AW(AW), .INIT_LEVEL(1'b0)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ce_sample  (ce_sample),
        .motor      (motor),
        .flush      (flush),
        .din        (din),
        .din_wr     (din_wr),
        .din_ready  (din_ready),
        .tape_level (tape_level),
        .active     (active),
        .underrun   (underrun),
        .fifo_count (fifo_count)
    );

    typedef struct {
        logic        lvl;
        int unsigned at;
    } tog_t;

    tog_t        q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned qcnt = 0;
    int unsigned scnt = 0;
    bit          ce_en = 1'b0;
    bit          mon_en = 1'b0;
    int unsigned base;

    always #5 clk_sys = ~clk_sys;

    // ce_sample: one clk every 12
    initial begin
        int ph = 0;
        forever begin
            @(negedge clk_sys);
            ph = (ph == 11) ? 0 : ph + 1;
            ce_sample = ce_en && (ph == 0);
        end
    end

    always @(posedge clk_sys) begin
        if (ce_sample) scnt <= scnt + 1;
        if (ce_sample && motor && reset_n && !flush) qcnt <= qcnt + 1;
    end

    // Monitor: every level change must match the head of the queue
    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (tape_level !== prev) begin
                if (mon_en) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL toggle: unexpected level %0b at strobe %0d", tape_level, qcnt);
                    end else begin
                        tog_t e;
                        e = q.pop_front();
                        if (tape_level !== e.lvl || qcnt != e.at) begin
                            bad++;
                            $display("FAIL toggle: got level %0b at strobe %0d, want level %0b at strobe %0d",
                                     tape_level, qcnt, e.lvl, e.at);
                        end
                    end
                end
                prev = tape_level;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        @(negedge clk_sys);
        din    = b;
        din_wr = 1'b1;
    endtask

    task automatic wr_end();
        @(negedge clk_sys);
        din_wr = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic push(input logic l, input int unsigned at);
        tog_t e;
        e.lvl = l;
        e.at  = at;
        q.push_back(e);
    endtask

    task automatic drain(input string name, input int max);
        int n = 0;
        while (q.size() != 0 && n < max) begin
            @(negedge clk_sys);
            n++;
        end
        chk(name, q.size(), 0);
    endtask

    task automatic wait_q(input int unsigned tgt, input int max);
        int n = 0;
        while (qcnt < tgt && n < max) begin
            @(negedge clk_sys);
            n++;
        end
        chk("strobe wait", qcnt, tgt);
    endtask

    task automatic do_flush();
        mon_en = 1'b0;
        @(negedge clk_sys);
        flush = 1'b1;
        @(negedge clk_sys);
        flush = 1'b0;
        @(negedge clk_sys);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst level", tape_level, 0);
        chk("rst active", active, 0);
        chk("rst underrun", underrun, 0);
        chk("rst count", fifo_count, 0);
        chk("rst ready", din_ready, 1);
        cyc(3);
        reset_n = 1'b1;
        ce_en   = 1'b1;
        cyc(2);
        mon_en  = 1'b1;

        // Short pulses 3,2 then underrun
        wr(8'h03); wr(8'h02); wr_end();
        cyc(10);
        base = qcnt;
        push(1'b1, base + 3);
        push(1'b0, base + 5);
        motor = 1'b1;
        drain("t1 toggles", 200);
        cyc(20);
        chk("t1 underrun", underrun, 1);
        chk("t1 count", fifo_count, 0);

        // Extended 1000 followed by 1
        motor = 1'b0;
        wr(8'h00); wr(8'hE8); wr(8'h03); wr(8'h00); wr(8'h00); wr(8'h01); wr_end();
        cyc(20);
        base = qcnt;
        push(1'b1, base + 1000);
        push(1'b0, base + 1001);
        motor = 1'b1;
        drain("t2 toggles", 15000);
        cyc(5);

        // Motor pause mid-pulse
        motor = 1'b0;
        wr(8'h05); wr_end();
        cyc(10);
        base = qcnt;
        push(1'b1, base + 5);
        motor = 1'b1;
        wait_q(base + 2, 100);
        chk("t3 active run", active, 1);
        motor = 1'b0;
        cyc(3);
        chk("t3 active paused", active, 0);
        begin
            int unsigned s0 = scnt;
            int n = 0;
            while (scnt < s0 + 100 && n < 2000) begin
                @(negedge clk_sys);
                n++;
            end
        end
        chk("t3 no count paused", qcnt, base + 2);
        chk("t3 level held", tape_level, 0);
        motor = 1'b1;
        drain("t3 toggle", 200);
        cyc(20);

        // Fill FIFO with motor off, then flush
        motor = 1'b0;
        chk("t4 underrun pre", underrun, 1);
        chk("t4 level pre", tape_level, 1);
        for (int i = 0; i < (1 << AW) + 3; i++) wr(8'h05);
        wr_end();
        cyc(2);
        chk("t4 full count", fifo_count, 1 << AW);
        chk("t4 ready full", din_ready, 0);
        do_flush();
        chk("t4 flush count", fifo_count, 0);
        chk("t4 flush level", tape_level, 0);
        chk("t4 flush underrun", underrun, 0);
        chk("t4 flush ready", din_ready, 1);
        chk("t4 flush active", active, 0);
        cyc(2);
        mon_en = 1'b1;

        // Zero extended length discarded, then 2
        wr(8'h00); wr(8'h00); wr(8'h00); wr(8'h00); wr(8'h00); wr(8'h02); wr_end();
        cyc(20);
        chk("t5 no underrun yet", underrun, 0);
        chk("t5 count", fifo_count, 0);
        base = qcnt;
        push(1'b1, base + 2);
        motor = 1'b1;
        drain("t5 toggle", 200);
        cyc(20);
        chk("t5 underrun after", underrun, 1);

        // Async reset mid-PLAY
        motor = 1'b0;
        wr(8'h30); wr(8'h30); wr_end();
        cyc(10);
        chk("t6 count pre", fifo_count, 1);
        base = qcnt;
        motor = 1'b1;
        wait_q(base + 3, 100);
        chk("t6 active pre", active, 1);
        mon_en = 1'b0;
        @(posedge clk_sys);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6 async level", tape_level, 0);
        chk("t6 async active", active, 0);
        chk("t6 async count", fifo_count, 0);
        chk("t6 async ready", din_ready, 1);
        chk("t6 async underrun", underrun, 0);
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        chk("end queue", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
